// File: rtl/ack_nak_generator_if.sv
// Receive-side TLP strobe/verdict and Ack/Nak DLLP request bundle.
// The generator is the slave; the link/transmit environment is the master.
interface ack_nak_generator_if;
   logic        rx_tlp_vld_i;
   logic [11:0] rx_seq_num_i;
   logic        rx_lcrc_ok_i;
   logic        rx_tlp_accept_o;
   logic        rx_tlp_drop_o;
   logic        ack_nack_o;
   logic        ack_nack_vld_o;
   logic [11:0] ack_seq_num_o;
   logic        ack_nack_rdy_i;

   modport master (
      output rx_tlp_vld_i, rx_seq_num_i, rx_lcrc_ok_i, ack_nack_rdy_i,
      input  rx_tlp_accept_o, rx_tlp_drop_o, ack_nack_o, ack_nack_vld_o, ack_seq_num_o
   );

   modport slave (
      input  rx_tlp_vld_i, rx_seq_num_i, rx_lcrc_ok_i, ack_nack_rdy_i,
      output rx_tlp_accept_o, rx_tlp_drop_o, ack_nack_o, ack_nack_vld_o, ack_seq_num_o
   );
endinterface

// File: rtl/ack_nak_generator.sv
// Data-link receive sequencing: classifies TLPs, accepts/drops one cycle later, and requests Ack/Nak DLLPs.
// DLLP request is registered (vld one cycle after scheduling) and held stable until ack_nack_rdy_i.
module ack_nak_generator #(
   parameter int ACK_LATENCY = 255,
   parameter int ACK_FREQ    = 4
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   ack_nak_generator_if.slave  bus,
   output logic [11:0]         next_rcv_seq_o,
   output logic                nak_scheduled_o
);

   localparam int CW = $clog2(ACK_FREQ + 1);
   localparam int TW = $clog2(ACK_LATENCY + 1);
   localparam logic [CW-1:0] FREQ_MAX = CW'(ACK_FREQ);
   localparam logic [TW-1:0] TMR_MAX  = TW'(ACK_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, SEND_ACK, SEND_NAK} state_t;

   state_t          state_q, state_d;
   logic [11:0]     next_seq_q, next_seq_d;
   logic            nak_sched_q, nak_sched_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [CW-1:0]   rearm_q, rearm_d, rearm_inc;
   logic [TW-1:0]   timer_q, timer_d;
   logic            pend_nak_q, pend_nak_d;
   logic            pend_ack_q, pend_ack_d;
   logic            accept_q, drop_q;
   logic            vld_q, ack_nack_q;
   logic [11:0]     ack_seq_q;

   logic [11:0]     seq_diff;
   logic            in_seq, dup, nak_evt;
   logic            handshake, ack_hs;
   logic            timer_exp, ack_ok;
   logic            sched_nak, sched_ack;
   logic            load_ack, load_nak, busy;

   // Classification of the current strobe against NEXT_RCV_SEQ (mod 4096)
   always_comb begin
      seq_diff = next_seq_q - bus.rx_seq_num_i;
      in_seq   = bus.rx_tlp_vld_i && bus.rx_lcrc_ok_i && (seq_diff == 12'd0);
      dup      = bus.rx_tlp_vld_i && bus.rx_lcrc_ok_i && (seq_diff != 12'd0) && (seq_diff <= 12'd2048);
      nak_evt  = bus.rx_tlp_vld_i && !in_seq && !dup && !nak_sched_q;
   end

   always_comb begin
      handshake   = vld_q && bus.ack_nack_rdy_i;
      ack_hs      = handshake && (state_q == SEND_ACK);
      next_seq_d  = in_seq ? next_seq_q + 12'd1 : next_seq_q;
      nak_sched_d = in_seq ? 1'b0 : (nak_evt ? 1'b1 : nak_sched_q);

      cnt_inc   = (in_seq && (cnt_q != FREQ_MAX)) ? cnt_q + CW'(1) : cnt_q;
      rearm_inc = (in_seq && (rearm_q != FREQ_MAX)) ? rearm_q + CW'(1) : rearm_q;
      // TLPs accepted after the Ack field was latched seed the count once that Ack completes
      cnt_d     = ack_hs ? rearm_inc : cnt_inc;
      rearm_d   = ((state_q == SEND_ACK) && !ack_hs) ? rearm_inc : '0;

      if (ack_hs || (cnt_q == '0) || nak_sched_q)
         timer_d = '0;
      else if (timer_q == TMR_MAX)
         timer_d = timer_q;
      else
         timer_d = timer_q + TW'(1);

      timer_exp = (cnt_q != '0) && !nak_sched_q && (timer_q == TMR_MAX);
      ack_ok    = !nak_sched_d;
      sched_nak = nak_evt || pend_nak_q;
      sched_ack = dup || pend_ack_q || (ack_ok && ((cnt_inc == FREQ_MAX) || timer_exp));
   end

   // FSM: state register
   always_ff @(posedge clk_i) begin
      if (!rst_n_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // FSM: next state (Nak wins over a simultaneous Ack)
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (sched_nak)
               state_d = SEND_NAK;
            else if (sched_ack)
               state_d = SEND_ACK;
         end
         SEND_ACK, SEND_NAK: begin
            if (handshake)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy     = (state_q != IDLE);
      load_ack = (state_q == IDLE) && (state_d == SEND_ACK);
      load_nak = (state_q == IDLE) && (state_d == SEND_NAK);
   end

   // Requests arriving while busy (or losing to a Nak) wait until they can be loaded
   always_comb begin
      pend_nak_d = (pend_nak_q || (nak_evt && busy)) && !load_nak;
      pend_ack_d = (pend_ack_q || dup) && !load_ack;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         next_seq_q  <= 12'd0;
         nak_sched_q <= 1'b0;
         cnt_q       <= '0;
         rearm_q     <= '0;
         timer_q     <= '0;
         pend_nak_q  <= 1'b0;
         pend_ack_q  <= 1'b0;
         accept_q    <= 1'b0;
         drop_q      <= 1'b0;
         vld_q       <= 1'b0;
         ack_nack_q  <= 1'b0;
         ack_seq_q   <= 12'd0;
      end else begin
         next_seq_q  <= next_seq_d;
         nak_sched_q <= nak_sched_d;
         cnt_q       <= cnt_d;
         rearm_q     <= rearm_d;
         timer_q     <= timer_d;
         pend_nak_q  <= pend_nak_d;
         pend_ack_q  <= pend_ack_d;
         accept_q    <= in_seq;
         drop_q      <= bus.rx_tlp_vld_i && !in_seq;
         if (load_ack || load_nak) begin
            vld_q      <= 1'b1;
            ack_nack_q <= load_ack;
            ack_seq_q  <= next_seq_d - 12'd1;
         end else if (handshake) begin
            vld_q <= 1'b0;
         end
      end
   end

   assign bus.rx_tlp_accept_o = accept_q;
   assign bus.rx_tlp_drop_o   = drop_q;
   assign bus.ack_nack_o      = ack_nack_q;
   assign bus.ack_nack_vld_o  = vld_q;
   assign bus.ack_seq_num_o   = ack_seq_q;
   assign next_rcv_seq_o      = next_seq_q;
   assign nak_scheduled_o     = nak_sched_q;

endmodule
